regfile_wb_arbiter: RTL

- Shares the single register-file write port between two writeback requesters: req0 (ALU result) and req1 (load result).
- Round-robin arbitration. Each requester uses a valid/ready handshake.
- The granted write is registered and driven to the register file one cycle later.
- Writes to x0 are dropped. A saturating counter records contention cycles for performance debug.

---
 rtl/regfile_wb_arbiter.sv | 88 ++++++++
 1 files changed

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register-file write port between the ALU
// (req0) and load (req1) writeback paths, with a registered write stage.
module regfile_wb_arbiter #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic [CNT_W-1:0]  conflict_cnt
);

  logic              last_grant_q, last_grant_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              grant0, grant1, grant_any, contend;
  logic [ADDR_W-1:0] gnt_addr;
  logic [DATA_W-1:0] gnt_data;

  // last_grant_q=1 means req1 won last, so req0 has priority on contention.
  always_comb begin
    contend   = req0_valid && req1_valid;
    grant0    = !reset && !stall && req0_valid && (!req1_valid || last_grant_q);
    grant1    = !reset && !stall && req1_valid && (!req0_valid || !last_grant_q);
    grant_any = grant0 || grant1;
    gnt_addr  = grant1 ? req1_addr : req0_addr;
    gnt_data  = grant1 ? req1_data : req0_data;
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  always_comb begin
    last_grant_d = last_grant_q;
    wr_en_d      = wr_en_q;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    cnt_d        = cnt_q;
    if (!stall) begin
      wr_en_d = grant_any && (gnt_addr != '0);
      if (grant_any) begin
        last_grant_d = grant1;
        wr_addr_d    = gnt_addr;
        wr_data_d    = gnt_data;
      end
      if (contend && (cnt_q != '1)) begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant_q <= 1'b1;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      cnt_q        <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      cnt_q        <= cnt_d;
    end
  end

  assign wr_en        = wr_en_q;
  assign wr_addr      = wr_addr_q;
  assign wr_data      = wr_data_q;
  assign conflict_cnt = cnt_q;

endmodule
